wm_phase_timer: RTL

Phase-duration timer feeding the washing-machine control FSM.
- Consumes the FSM's timer_enable, phase_sel and the mode buttons; looks up the duration for the current phase and wash mode.
- Counts that duration down in prescaled time units and returns a single-cycle timer_done pulse, which advances the FSM to its next phase.
- Pauses while the lid is open and exposes the remaining time for a display.

---
 rtl/wm_phase_timer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/wm_phase_timer.sv
// Phase-duration timer for the washing-machine controller: looks up the duration
// of the active phase for the latched wash mode and counts it down in prescaled ticks.
module wm_phase_timer #(
    parameter int CLK_DIV = 1000,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             timer_enable,
    input  logic [1:0]       phase_sel,
    input  logic             mode1,
    input  logic             mode2,
    input  logic             mode3,
    input  logic             lid,
    output logic             timer_done,
    output logic [CNT_W-1:0] remaining,
    output logic             busy,
    output logic             paused,
    output logic [1:0]       mode_q,
    output logic [1:0]       state_dbg
);

    localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t            state_q, state_d;
    logic              en_q;
    logic [1:0]        phase_q;
    logic [PW-1:0]     presc_q, presc_d;
    logic [CNT_W-1:0]  rem_d;
    logic              done_d;
    logic [1:0]        mode_cap, mode_d;
    logic              load;
    logic              tick;

    function automatic logic [3:0] duration(input logic [1:0] mode, input logic [1:0] phase);
        logic [3:0] d;
        d = 4'd0;
        case (mode)
            2'b01: case (phase)
                2'b00: d = 4'd2;
                2'b01: d = 4'd4;
                2'b10: d = 4'd2;
                default: d = 4'd2;
            endcase
            2'b10: case (phase)
                2'b00: d = 4'd4;
                2'b01: d = 4'd8;
                2'b10: d = 4'd4;
                default: d = 4'd3;
            endcase
            2'b11: case (phase)
                2'b00: d = 4'd6;
                2'b01: d = 4'd12;
                2'b10: d = 4'd6;
                default: d = 4'd4;
            endcase
            default: d = 4'd0;
        endcase
        return d;
    endfunction

    // Heaviest pressed button wins; no button at all defaults to normal.
    always_comb begin
        if (mode3)      mode_cap = 2'b11;
        else if (mode2) mode_cap = 2'b10;
        else if (mode1) mode_cap = 2'b01;
        else            mode_cap = 2'b10;
    end

    always_comb begin
        mode_d = mode_q;
        if (!timer_enable) mode_d = 2'b00;
        else if (!en_q)    mode_d = mode_cap;
    end

    assign load = timer_enable & (~en_q | (phase_sel != phase_q));
    assign tick = (presc_q == PW'(CLK_DIV - 1));

    always_comb begin
        state_d = state_q;
        rem_d   = remaining;
        presc_d = presc_q;
        done_d  = 1'b0;
        if (!timer_enable) begin
            state_d = IDLE;
            rem_d   = '0;
            presc_d = '0;
        end else if (load) begin
            rem_d   = CNT_W'(duration(mode_d, phase_sel));
            presc_d = '0;
            state_d = lid ? PAUSE : RUN;
        end else begin
            case (state_q)
                RUN, PAUSE: begin
                    // A closed lid in PAUSE resumes counting on the same edge, so a
                    // lid-open window of N cycles delays expiry by exactly N cycles.
                    if (lid) begin
                        state_d = PAUSE;
                    end else begin
                        state_d = RUN;
                        if (tick) begin
                            presc_d = '0;
                            rem_d   = remaining - CNT_W'(1);
                            if (remaining == CNT_W'(1)) begin
                                done_d  = 1'b1;
                                state_d = DONE;
                            end
                        end else begin
                            presc_d = presc_q + PW'(1);
                        end
                    end
                end
                DONE:    rem_d = '0;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            en_q       <= 1'b0;
            phase_q    <= 2'b00;
            presc_q    <= '0;
            remaining  <= '0;
            timer_done <= 1'b0;
            mode_q     <= 2'b00;
        end else begin
            state_q    <= state_d;
            en_q       <= timer_enable;
            phase_q    <= phase_sel;
            presc_q    <= presc_d;
            remaining  <= rem_d;
            timer_done <= done_d;
            mode_q     <= mode_d;
        end
    end

    assign busy      = (state_q == RUN) | (state_q == PAUSE);
    assign paused    = (state_q == PAUSE);
    assign state_dbg = state_q;

endmodule
